// File: rtl/ewb_pmem_arbiter.sv
// Shares the single pmem port between L2 line fills and eviction-write-buffer drains.
// Reads win over writebacks, reads that hit the buffered line are forwarded, and a counter bounds writeback starvation.
module ewb_pmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         l2_read,
    input  logic [31:0]  l2_address,
    output logic [255:0] l2_rdata,
    output logic         l2_resp,
    input  logic         ewb_valid,
    input  logic [31:0]  ewb_address,
    input  logic [255:0] ewb_wdata,
    output logic         ewb_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t       state, state_d;
    logic         done_wr, done_wr_d;
    logic [3:0]   starve_cnt, starve_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] data_q, data_d;
    logic         line_match;

    assign line_match = (l2_address[31:5] == ewb_address[31:5]);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d   = state;
        done_wr_d = done_wr;
        starve_d  = starve_cnt;
        addr_d    = addr_q;
        data_d    = data_q;

        unique case (state)
            IDLE: begin
                if (l2_read && ewb_valid && line_match) begin
                    data_d    = ewb_wdata;
                    done_wr_d = 1'b0;
                    state_d   = DONE;
                end else if (ewb_valid && starve_cnt == LIMIT) begin
                    addr_d   = ewb_address;
                    data_d   = ewb_wdata;
                    starve_d = '0;
                    state_d  = WRITE;
                end else if (l2_read) begin
                    addr_d   = l2_address;
                    // Cannot already be at LIMIT here with ewb_valid set: that case forced a write above.
                    starve_d = ewb_valid ? starve_cnt + 4'd1 : '0;
                    state_d  = READ;
                end else if (ewb_valid) begin
                    addr_d   = ewb_address;
                    data_d   = ewb_wdata;
                    starve_d = '0;
                    state_d  = WRITE;
                end else begin
                    starve_d = '0;
                end
            end
            READ: begin
                if (pmem_resp) begin
                    data_d    = pmem_rdata;
                    done_wr_d = 1'b0;
                    state_d   = DONE;
                end
            end
            WRITE: begin
                if (pmem_resp) begin
                    done_wr_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            done_wr    <= 1'b0;
            starve_cnt <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state      <= state_d;
            done_wr    <= done_wr_d;
            starve_cnt <= starve_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Outputs are gated by state so the port is quiet outside an active access.
    assign pmem_read    = (state == READ);
    assign pmem_write   = (state == WRITE);
    assign pmem_address = (pmem_read || pmem_write) ? addr_q : '0;
    assign pmem_wdata   = pmem_write ? data_q : '0;
    assign l2_resp      = (state == DONE) && !done_wr;
    assign ewb_resp     = (state == DONE) && done_wr;
    assign l2_rdata     = l2_resp ? data_q : '0;

endmodule

// File: doc/ewb_pmem_arbiter.md
# ewb_pmem_arbiter

Sequencer that shares the single physical-memory port between L2 line fills (reads) and eviction-write-buffer drains (writebacks). Sits between the L2 cache / eviction write buffer and pmem. Serves L2 reads first to cut miss latency, forwards a read that hits the buffered evicted line directly from the buffer, and bounds writeback starvation with a counter.

## Interface
- STARVE_LIMIT, 4: consecutive reads granted while a writeback is pending before a writeback is forced; range 1..15.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- l2_read  in  1  L2 line-fill request; held until `l2_resp`.
- l2_address  in  32  fill address; stable while `l2_read` is high.
- l2_rdata  out  256  fill data; valid when `l2_resp` is high.
- l2_resp  out  1  one-cycle fill-complete pulse.
- ewb_valid  in  1  eviction buffer holds a dirty line; held until `ewb_resp`.
- ewb_address  in  32  evicted line address.
- ewb_wdata  in  256  evicted line data.
- ewb_resp  out  1  one-cycle pulse: line written to pmem, buffer may clear.
- pmem_read  out  1  pmem read strobe.
- pmem_write  out  1  pmem write strobe.
- pmem_address  out  32  pmem line address.
- pmem_wdata  out  256  pmem write data.
- pmem_rdata  in  256  pmem read data; valid with `pmem_resp`.
- pmem_resp  in  1  pmem completion.

## Operation
- States:
  - IDLE: no pmem access.
  - READ: fill in progress.
  - WRITE: drain in progress.
  - DONE: response cycle.
- Line match: `l2_address[31:5] == ewb_address[31:5]`.
- IDLE decision, evaluated each cycle, first true wins:
  - `l2_read` & `ewb_valid` & match: forward. Latch `ewb_wdata` into the data register, go to DONE as a read. No pmem access.
  - `ewb_valid` & starve_cnt == STARVE_LIMIT: latch `ewb_address`/`ewb_wdata`, go to WRITE.
  - `l2_read`: latch `l2_address`, go to READ. If `ewb_valid`, increment starve_cnt.
  - `ewb_valid`: latch address/data, go to WRITE.
- READ: `pmem_read`=1, `pmem_address`=latched address. On `pmem_resp`, register `pmem_rdata` and go to DONE.
- WRITE: `pmem_write`=1, `pmem_address`/`pmem_wdata`=latched values. On `pmem_resp`, go to DONE.
- DONE: pulse `l2_resp` (read or forward) or `ewb_resp` (write) for exactly one cycle, then go to IDLE.
- starve_cnt (4-bit, saturating at STARVE_LIMIT):
  - Cleared when a WRITE is granted, or whenever `ewb_valid`=0 in IDLE.
  - Never incremented by a forward.
- Address and data are latched at grant. Requester input changes during READ/WRITE are ignored.
- Requesters drop their request in the cycle after their resp. Because DONE is followed by IDLE, the arbiter evaluates requests one cycle after the pulse.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, starve_cnt=0, data/address registers=0. All outputs 0: `l2_resp`, `ewb_resp`, `pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `l2_rdata`.
- Reset mid-READ/WRITE: strobes drop at the next edge. No resp is issued. A late `pmem_resp` in IDLE is ignored.
- Strobes are asserted from the cycle after grant. They are held with stable address/data through the `pmem_resp` cycle and are 0 in DONE.
- Read latency: grant edge, then READ cycles until `pmem_resp`, then `l2_resp` in the following cycle. Minimum 3 cycles from the first `l2_read` cycle in IDLE (IDLE, READ with immediate `pmem_resp`, DONE).
- Forward latency: `l2_resp` in the 2nd cycle (IDLE, DONE). `pmem_*` stays idle.
- `l2_resp` and `ewb_resp` are never high together. `pmem_read` and `pmem_write` are never high together.
- `pmem_resp` outside READ/WRITE is ignored.
- Simultaneous `l2_read` and `ewb_valid` with no match and starve_cnt < STARVE_LIMIT: read wins.

## Test plan
- Reset, then a single read:
  - Stimulus: `rst_n`=0 for 2 cycles with `l2_read`=1; release; `pmem_resp` 3 cycles after `pmem_read` rises, `pmem_rdata`=0xA5…A5.
  - Response: all outputs 0 during reset. `pmem_read` high with `pmem_address`=0x1000_0020. One-cycle `l2_resp` with `l2_rdata`=0xA5…A5.
- Writeback only:
  - Stimulus: `ewb_valid`=1, `ewb_address`=0x0000_4040, `ewb_wdata`=0x1234…, `l2_read`=0.
  - Response: `pmem_write` with that address/data until `pmem_resp`, then a single `ewb_resp` pulse. `l2_resp` stays 0.
- Forward on match:
  - Stimulus: `ewb_valid`=1, `ewb_address`=0x0000_4040; `l2_read` with `l2_address`=0x0000_405C.
  - Response: `l2_resp` in the 2nd cycle with `l2_rdata`=`ewb_wdata`. `pmem_read`/`pmem_write` stay 0. `ewb_resp` stays 0. starve_cnt is unchanged.
- Read priority and starvation bound, STARVE_LIMIT=4:
  - Stimulus: `ewb_valid` held; 6 back-to-back non-matching reads.
  - Response: the first 4 are served as reads, the 5th grant is WRITE with `ewb_resp`, then the remaining reads are served.
- Reset mid-WRITE:
  - Stimulus: assert `rst_n`=0 two cycles into WRITE; pulse `pmem_resp` during reset and once after release.
  - Response: `pmem_write` drops at the reset edge. No `ewb_resp`. After release with `ewb_valid` still 1, a fresh WRITE is issued.
- Late/stray response:
  - Stimulus: `pmem_resp`=1 while in IDLE with no requests.
  - Response: no state change, no resp pulses.
